// File: rtl/raster_irq_ctrl_m.sv
// Raster timing generator (sync, counters, pixel coordinates, windows, fetch strobe) with a small
// CPU register file driving a registered, maskable, write-1-to-clear interrupt from three sources.
module raster_irq_ctrl_m #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int SYNC_POL     = 0,
    parameter int X_OFFSET     = 32,
    parameter int X_WIDTH      = 256,
    parameter int Y_WIDTH      = 240,
    parameter int LINE_REPEAT  = 2,
    parameter int FETCH_CYCLES = 32
) (
    input  logic       gpu_clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] hcounter,
    output logic [9:0] vcounter,
    output logic       visible,
    output logic       drawing,
    output logic [8:0] current_x,
    output logic [8:0] current_y,
    output logic       writable,
    output logic       start_fetch,
    input  logic       reg_sel,
    input  logic [1:0] reg_addr,
    input  logic       reg_we,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic       irq
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] FETCH_N  = 10'(FETCH_CYCLES);
    localparam logic [8:0] X_OFF    = 9'(X_OFFSET);
    localparam logic [9:0] X_W      = 10'(X_WIDTH);
    localparam logic [9:0] Y_W      = 10'(Y_WIDTH);
    localparam logic [9:0] LR_MASK  = 10'(LINE_REPEAT - 1);
    localparam int         Y_SHIFT  = (LINE_REPEAT == 4) ? 2 : (LINE_REPEAT == 2) ? 1 : 0;
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    logic [9:0] hcounter_q, hcounter_d;
    logic [9:0] vcounter_q, vcounter_d;
    logic [2:0] pending_q, pending_d;
    logic [2:0] enable_q, enable_d;
    logic [7:0] line_cmp_q, line_cmp_d;
    logic       irq_q, irq_d;

    logic       hs_act, vs_act;
    logic [2:0] events;
    logic [2:0] status_clr;

    // Timing outputs decode the counter registers directly, no pipeline stage.
    assign hcounter    = hcounter_q;
    assign vcounter    = vcounter_q;
    assign hs_act      = (hcounter_q >= HS_START) && (hcounter_q < HS_END);
    assign vs_act      = (vcounter_q >= VS_START) && (vcounter_q < VS_END);
    assign hsync       = hs_act ? SYNC_ACT : ~SYNC_ACT;
    assign vsync       = vs_act ? SYNC_ACT : ~SYNC_ACT;
    assign visible     = (hcounter_q < H_VIS) && (vcounter_q < V_VIS);
    assign current_x   = hcounter_q[8:0] - X_OFF;
    assign current_y   = 9'(vcounter_q >> Y_SHIFT);
    assign drawing     = visible && ({1'b0, current_x} < X_W) && ({1'b0, current_y} < Y_W);
    assign writable    = (vcounter_q >= V_VIS);
    assign start_fetch = (hcounter_q < FETCH_N) && (vcounter_q == 10'd0);
    assign irq         = irq_q;

    // Line compare only fires on the first scanline of each repeated logical line.
    assign events[0] = (hcounter_q == 10'd0) && (vcounter_q == V_VIS);
    assign events[1] = (hcounter_q == 10'd0) && (vcounter_q == 10'd0);
    assign events[2] = (hcounter_q == 10'd0) && (vcounter_q < V_VIS)
                       && ((vcounter_q & LR_MASK) == 10'd0)
                       && (current_y[7:0] == line_cmp_q);

    always_comb begin
        hcounter_d = hcounter_q + 10'd1;
        vcounter_d = vcounter_q;
        if (hcounter_q == H_LAST) begin
            hcounter_d = 10'd0;
            vcounter_d = (vcounter_q == V_LAST) ? 10'd0 : vcounter_q + 10'd1;
        end

        enable_d   = enable_q;
        line_cmp_d = line_cmp_q;
        status_clr = 3'b000;
        if (reg_sel && reg_we) begin
            case (reg_addr)
                2'd0:    status_clr = reg_wdata[2:0];
                2'd1:    enable_d   = reg_wdata[2:0];
                2'd2:    line_cmp_d = reg_wdata;
                default: ;
            endcase
        end

        // Set is applied after clear so a coincident event is never lost.
        pending_d = (pending_q & ~status_clr) | events;
        irq_d     = |(pending_q & enable_q);
    end

    always_comb begin
        reg_rdata = 8'h00;
        if (reg_sel) begin
            case (reg_addr)
                2'd0:    reg_rdata = {writable, 4'b0000, pending_q};
                2'd1:    reg_rdata = {5'b00000, enable_q};
                2'd2:    reg_rdata = line_cmp_q;
                default: reg_rdata = current_y[7:0];
            endcase
        end
    end

    // irq resets high to match the legacy controller.
    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            hcounter_q <= 10'd0;
            vcounter_q <= 10'd0;
            pending_q  <= 3'b001;
            enable_q   <= 3'b011;
            line_cmp_q <= 8'd0;
            irq_q      <= 1'b1;
        end else begin
            hcounter_q <= hcounter_d;
            vcounter_q <= vcounter_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            line_cmp_q <= line_cmp_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_raster_irq_ctrl_m.sv
// Bench for raster_irq_ctrl_m on a shrunken raster: a cycle-indexed reference model checks every
// output each cycle, directed steps hit the timing/interrupt corner cases, then random register traffic.
module tb_raster_irq_ctrl_m;

    localparam int HV = 40, HF = 4, HS = 8, HB = 8;
    localparam int VV = 30, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int XO = 8, XW = 24, YW = 12, LR = 2, FC = 6;

    logic       gpu_clk = 1'b0;
    logic       rst = 1'b1;
    logic       reg_sel = 1'b0;
    logic [1:0] reg_addr = 2'd0;
    logic       reg_we = 1'b0;
    logic [7:0] reg_wdata = 8'h00;

    logic       a_hsync, a_vsync, a_visible, a_drawing, a_writable, a_start_fetch, a_irq;
    logic [9:0] a_hcounter, a_vcounter;
    logic [8:0] a_current_x, a_current_y;
    logic [7:0] a_reg_rdata;

    logic       b_hsync, b_vsync, b_visible, b_drawing, b_writable, b_start_fetch, b_irq;
    logic [9:0] b_hcounter, b_vcounter;
    logic [8:0] b_current_x, b_current_y;
    logic [7:0] b_reg_rdata;

    always #5 gpu_clk = ~gpu_clk;

    raster_irq_ctrl_m #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(0), .X_OFFSET(XO), .X_WIDTH(XW), .Y_WIDTH(YW),
        .LINE_REPEAT(LR), .FETCH_CYCLES(FC)
    ) dut_a (
        .gpu_clk(gpu_clk), .rst(rst), .hsync(a_hsync), .vsync(a_vsync),
        .hcounter(a_hcounter), .vcounter(a_vcounter), .visible(a_visible),
        .drawing(a_drawing), .current_x(a_current_x), .current_y(a_current_y),
        .writable(a_writable), .start_fetch(a_start_fetch), .reg_sel(reg_sel),
        .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .reg_rdata(a_reg_rdata), .irq(a_irq)
    );

    raster_irq_ctrl_m #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1), .X_OFFSET(XO), .X_WIDTH(XW), .Y_WIDTH(YW),
        .LINE_REPEAT(1), .FETCH_CYCLES(FC)
    ) dut_b (
        .gpu_clk(gpu_clk), .rst(rst), .hsync(b_hsync), .vsync(b_vsync),
        .hcounter(b_hcounter), .vcounter(b_vcounter), .visible(b_visible),
        .drawing(b_drawing), .current_x(b_current_x), .current_y(b_current_y),
        .writable(b_writable), .start_fetch(b_start_fetch), .reg_sel(reg_sel),
        .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .reg_rdata(b_reg_rdata), .irq(b_irq)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: position is just the cycle index within the frame.
    int mt, m_pend, m_en, m_cmp, m_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mt = 0; m_pend = 1; m_en = 3; m_cmp = 0; m_irq = 1;
    endtask

    task automatic tick();
        int h, v, cx, cy, hs_act, vs_act, vis, drw, wrt, rd, ev, clr, n_irq;
        @(negedge gpu_clk);
        h = mt % HT;
        v = mt / HT;
        cx = ((h % 512) - XO + 512) % 512;
        cy = (v / LR) % 512;
        hs_act = (h >= HV + HF && h < HV + HF + HS) ? 1 : 0;
        vs_act = (v >= VV + VF && v < VV + VF + VS) ? 1 : 0;
        vis = (h < HV && v < VV) ? 1 : 0;
        drw = (vis == 1 && cx < XW && cy < YW) ? 1 : 0;
        wrt = (v >= VV) ? 1 : 0;
        if (!reg_sel) rd = 0;
        else if (reg_addr == 2'd0) rd = wrt * 128 + m_pend;
        else if (reg_addr == 2'd1) rd = m_en;
        else if (reg_addr == 2'd2) rd = m_cmp;
        else rd = cy % 256;

        chk("hcounter", a_hcounter, h);
        chk("vcounter", a_vcounter, v);
        chk("hsync", a_hsync, 1 - hs_act);
        chk("vsync", a_vsync, 1 - vs_act);
        chk("visible", a_visible, vis);
        chk("drawing", a_drawing, drw);
        chk("current_x", a_current_x, cx);
        chk("current_y", a_current_y, cy);
        chk("writable", a_writable, wrt);
        chk("start_fetch", a_start_fetch, (h < FC && v == 0) ? 1 : 0);
        chk("reg_rdata", a_reg_rdata, rd);
        chk("irq", a_irq, m_irq);
        chk("b_hsync", b_hsync, hs_act);
        chk("b_vsync", b_vsync, vs_act);
        chk("b_current_y", b_current_y, v % 512);

        if (rst) begin
            model_reset();
        end else begin
            ev = 0;
            if (h == 0 && v == VV) ev |= 1;
            if (h == 0 && v == 0) ev |= 2;
            if (h == 0 && v < VV && v % LR == 0 && cy % 256 == m_cmp) ev |= 4;
            clr = (reg_sel && reg_we && reg_addr == 2'd0) ? (reg_wdata & 7) : 0;
            n_irq = ((m_pend & m_en) != 0) ? 1 : 0;
            m_pend = ((m_pend & ~clr) & 7) | ev;
            if (reg_sel && reg_we && reg_addr == 2'd1) m_en = reg_wdata & 7;
            if (reg_sel && reg_we && reg_addr == 2'd2) m_cmp = reg_wdata;
            m_irq = n_irq;
            mt = (mt + 1) % FRAME;
        end
        @(posedge gpu_clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (mt != target && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        if (mt != target) begin
            n_checks++;
            n_fail++;
            $error("FAIL run_to_timeout observed=%0d expected=%0d", mt, target);
        end
    endtask

    task automatic reg_write(input logic [1:0] addr, input logic [7:0] data);
        reg_sel = 1'b1; reg_we = 1'b1; reg_addr = addr; reg_wdata = data;
        tick();
        reg_sel = 1'b0; reg_we = 1'b0;
    endtask

    task automatic reg_peek(input logic [1:0] addr);
        reg_sel = 1'b1; reg_we = 1'b0; reg_addr = addr;
        #1;
    endtask

    initial begin
        // T1: reset, line wrap, frame wrap
        rst = 1'b1;
        @(posedge gpu_clk);
        #1;
        model_reset();
        rst = 1'b0;
        chk("t1_irq_after_reset", a_irq, 1);
        chk("t1_h_after_reset", a_hcounter, 0);
        run(HT);
        chk("t1_h_line", a_hcounter, 0);
        chk("t1_v_line", a_vcounter, 1);
        run_to(0);
        chk("t1_v_wrap", a_vcounter, 0);
        chk("t1_h_wrap", a_hcounter, 0);
        tick();
        reg_peek(2'd0);
        chk("t1_ev1_pending", a_reg_rdata[1], 1);
        reg_sel = 1'b0;

        // T2: clear everything, then vblank start raises irq two cycles later
        run(3);
        reg_write(2'd0, 8'h07);
        tick();
        chk("t2_irq_cleared", a_irq, 0);
        reg_peek(2'd0);
        chk("t2_status_zero", a_reg_rdata, 8'h00);
        reg_sel = 1'b0;
        run_to(VV * HT);
        chk("t2_writable", a_writable, 1);
        tick();
        chk("t2_irq_lag", a_irq, 0);
        tick();
        chk("t2_irq_rise", a_irq, 1);

        // T3: line compare only, single set per logical line
        reg_write(2'd1, 8'h04);
        reg_write(2'd2, 8'd5);
        reg_write(2'd0, 8'h07);
        run_to(10 * HT);
        tick();
        chk("t3_irq_lag", a_irq, 0);
        tick();
        chk("t3_irq_rise", a_irq, 1);
        reg_write(2'd0, 8'h04);
        run_to(11 * HT);
        run(2);
        chk("t3_no_repeat", a_irq, 0);

        // T4: clear collides with vblank start event
        reg_write(2'd1, 8'h01);
        run_to(VV * HT);
        tick();
        run_to(VV * HT);
        reg_write(2'd0, 8'h01);
        reg_peek(2'd0);
        chk("t4_set_wins", a_reg_rdata[0], 1);
        tick();
        reg_sel = 1'b0;
        chk("t4_irq_held", a_irq, 1);

        // T5: fetch strobe and drawing window edges
        run_to(FC - 1);
        chk("t5_fetch_last", a_start_fetch, 1);
        tick();
        chk("t5_fetch_end", a_start_fetch, 0);
        run_to(10 * HT + XO);
        chk("t5_x0", a_current_x, 0);
        chk("t5_y5", a_current_y, 5);
        chk("t5_draw_on", a_drawing, 1);
        run_to(10 * HT + XO + XW);
        chk("t5_draw_x_end", a_drawing, 0);
        run_to(2 * YW * HT + XO);
        chk("t5_draw_y_end", a_drawing, 0);

        // T6: mid-frame reset, reset coinciding with an event, alternate polarity instance
        run_to(20 * HT + 23);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_h", a_hcounter, 0);
        chk("t6_v", a_vcounter, 0);
        chk("t6_irq", a_irq, 1);
        reg_peek(2'd1);
        chk("t6_enable", a_reg_rdata, 8'h03);
        reg_sel = 1'b0;
        run_to(HV + HF);
        chk("t6_b_hsync_on", b_hsync, 1);
        run_to(HV + HF + HS);
        chk("t6_b_hsync_off", b_hsync, 0);
        reg_write(2'd0, 8'h07);
        run_to(VV * HT);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reg_peek(2'd0);
        chk("t6_event_dropped", a_reg_rdata, 8'h01);
        reg_sel = 1'b0;

        // Random register traffic, including writes without select and rare resets
        repeat (3 * FRAME) begin
            reg_sel = ($urandom_range(0, 99) < 20);
            reg_we = 1'($urandom_range(0, 1));
            reg_addr = 2'($urandom_range(0, 3));
            reg_wdata = (reg_addr == 2'd2) ? 8'($urandom_range(0, 16)) : 8'($urandom_range(0, 255));
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        reg_sel = 1'b0;
        reg_we = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
